// File: rtl/clm_state_decoder_pkg.sv
// clm_state_decoder_pkg: shared constants and types for the CLM state decoder
//
// CLM_D          default number of redundancy bits per encoded byte
// CLM_BLK        bytes per decoded AES state
// state_t        one CLM-encoded byte, [0:7] payload (bit 0 = MSB), [8:7+d] redundancy
// dec_matrix_t   d rows x 8 bits, systematic part of B_ext_MC
// clm_dec_state_t  collector FSM states
package clm_state_decoder_pkg;

    localparam int CLM_D   = 2;
    localparam int CLM_BLK = 16;

    typedef logic [0:7+CLM_D]          state_t;
    typedef logic [0:CLM_D-1][0:7]     dec_matrix_t;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } clm_dec_state_t;

endpackage

// File: rtl/clm_state_decoder_byte_decode.sv
// clm_byte_decode: combinational CLM byte decoder
//
// Parameters:
//   d        redundancy bits per encoded byte
// Ports:
//   in_data  [0:7+d]  encoded byte, [0:7] payload with bit 0 as MSB, [8+j] redundancy bit j
//   dec_B    d x 8    decode matrix rows
//   payload  [0:7]    in_data[0:7] XOR (XOR over j of in_data[8+j] AND dec_B[j])
module clm_byte_decode
    import clm_state_decoder_pkg::*;
#(
    parameter int d = CLM_D
) (
    input  logic [0:7+d]      in_data,
    input  logic [0:d-1][0:7] dec_B,
    output logic [0:7]        payload
);

    always_comb begin
        payload = in_data[0:7];
        for (int j = 0; j < d; j++)
            payload = payload ^ ({8{in_data[8+j]}} & dec_B[j]);
    end

endmodule

// File: rtl/clm_state_decoder.sv
// clm_state_decoder: collects 16 CLM-encoded bytes into a decoded AES state
//
// Optional feature: define CLM_DEC_PIPE_EN to register each accepted byte raw and
// decode it one cycle later (16th accept to out_valid = 2 cycles instead of 1).
//
// Parameters:
//   d          redundancy bits per encoded byte
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   in_data    encoded byte, [0:7] payload, [8:7+d] redundancy
//   in_valid   in_data valid
//   in_ready   block accepts in_data this cycle
//   dec_B      decode matrix, held stable from first accept until the block drains
//   flush      abort current block (wins over any simultaneous transfer)
//   out_block  decoded state, byte k = k-th accepted input
//   out_valid  out_block complete
//   out_ready  consumer takes out_block
module clm_state_decoder
    import clm_state_decoder_pkg::*;
#(
    parameter int d = CLM_D
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [0:7+d]             in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [0:d-1][0:7]        dec_B,
    input  logic                     flush,
    output logic [CLM_BLK-1:0][7:0]  out_block,
    output logic                     out_valid,
    input  logic                     out_ready
);

    clm_dec_state_t          state_q, state_d;
    logic [4:0]              acc_cnt_q, acc_cnt_d;
    logic [CLM_BLK-1:0][7:0] blk_q;
    logic [0:7+d]            dec_in;
    logic [0:7]              payload;
    logic                    accept;
    logic                    wr_en;
    logic [3:0]              wr_slot;

    assign in_ready  = (state_q == COLLECT) && (acc_cnt_q < 5'(CLM_BLK));
    assign out_valid = (state_q == DRAIN);
    assign out_block = blk_q;
    assign accept    = in_valid && in_ready;

`ifdef CLM_DEC_PIPE_EN
    logic [0:7+d] pipe_q;
    logic         pipe_v_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            pipe_q   <= '0;
            pipe_v_q <= 1'b0;
        end else begin
            pipe_v_q <= accept;
            if (accept)
                pipe_q <= in_data;
        end
    end

    // acc_cnt has already advanced past the byte sitting in the pipe
    assign dec_in  = pipe_q;
    assign wr_en   = pipe_v_q;
    assign wr_slot = acc_cnt_q[3:0] - 4'd1;
`else
    assign dec_in  = in_data;
    assign wr_en   = accept;
    assign wr_slot = acc_cnt_q[3:0];
`endif

    clm_byte_decode #(.d(d)) u_dec (
        .in_data (dec_in),
        .dec_B   (dec_B),
        .payload (payload)
    );

    always_comb begin
        state_d   = state_q;
        acc_cnt_d = acc_cnt_q;
        if (accept)
            acc_cnt_d = acc_cnt_q + 5'd1;
        if (state_q == COLLECT && wr_en && wr_slot == 4'(CLM_BLK - 1))
            state_d = DRAIN;
        if (state_q == DRAIN && out_ready) begin
            state_d   = COLLECT;
            acc_cnt_d = '0;
        end
        if (flush) begin
            state_d   = COLLECT;
            acc_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            acc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    // the buffer is only zeroed by reset/flush; a normal drain leaves it for overwrite
    always_ff @(posedge clk) begin
        if (!rst_n || flush)
            blk_q <= '0;
        else if (wr_en)
            blk_q[wr_slot] <= payload;
    end

endmodule

// File: tb/tb_clm_state_decoder.sv
// tb_clm_state_decoder: directed and randomized checks of clm_state_decoder
module tb_clm_state_decoder;

`ifdef CLM_DEC_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [0:9]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [0:1][0:7]      dec_B;
    logic                 flush;
    logic [15:0][7:0]     out_block;
    logic                 out_valid;
    logic                 out_ready;

    int n_chk  = 0;
    int n_fail = 0;
    int n_acc  = 0;
    logic [15:0][7:0] exp_blk;

    always #5 clk = ~clk;

    clm_state_decoder #(.d(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dec_B     (dec_B),
        .flush     (flush),
        .out_block (out_block),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic logic [7:0] ref_dec(input logic [7:0] p, input logic [1:0] r);
        logic [7:0] v;
        v = p;
        if (r[1]) v = v ^ dec_B[0];
        if (r[0]) v = v ^ dec_B[1];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p, input logic [1:0] r);
        int w;
        w = 0;
        in_data  = {p, r};
        in_valid = 1'b1;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        chk("accept_wait", in_ready, 1);
        if (in_ready) begin
            step();
            exp_blk[n_acc] = ref_dec(p, r);
            n_acc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_drain(input string tag);
        int lat;
        lat = 1;
        while (!out_valid && lat < 8) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_block"}, out_block, exp_blk);
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("take_valid", out_valid, 0);
        chk("take_ready", in_ready, 1);
        n_acc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        dec_B     = {8'h1B, 8'h80};
        step();
        step();
        rst_n = 1'b1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_block", out_block, 0);

        for (int i = 0; i < 16; i++) send(8'h53, 2'b00);
        expect_drain("plain53");
        chk("plain53_const", out_block, {16{8'h53}});

        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 10'($urandom);
            step();
            chk("hold_ready", in_ready, 0);
            chk("hold_valid", out_valid, 1);
            chk("hold_block", out_block, exp_blk);
        end
        in_valid = 1'b0;
        take_out();

        send(8'h53, 2'b10);
        send(8'h53, 2'b11);
        for (int i = 0; i < 14; i++) send(8'($urandom), 2'($urandom));
        expect_drain("rbits");
        chk("r10_byte", out_block[0], 8'h48);
        chk("r11_byte", out_block[1], 8'hC8);
        take_out();

        for (int i = 0; i < 7; i++) send(8'($urandom), 2'($urandom));
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_acc = 0;
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        chk("flush_block", out_block, 0);
        for (int i = 0; i < 16; i++) send(8'(i), 2'b00);
        expect_drain("ramp");
        chk("ramp_const", out_block, 128'h0F0E0D0C0B0A09080706050403020100);

        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        n_acc     = 0;
        chk("flushxfer_valid", out_valid, 0);
        chk("flushxfer_ready", in_ready, 1);
        chk("flushxfer_block", out_block, 0);
        send(8'hA5, 2'b00);
        step();
        chk("flushxfer_slot0", out_block[0], 8'hA5);
        for (int i = 1; i < 16; i++) send(8'($urandom), 2'($urandom));
        expect_drain("after_flushxfer");

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_acc = 0;
        chk("drainrst_valid", out_valid, 0);
        chk("drainrst_block", out_block, 0);
        chk("drainrst_ready", in_ready, 1);

        for (int b = 0; b < 4; b++) begin
            dec_B = {8'($urandom), 8'($urandom)};
            for (int i = 0; i < 16; i++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) step();
                send(8'($urandom), 2'($urandom));
            end
            expect_drain("rand");
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                step();
                chk("rand_hold", out_block, exp_blk);
            end
            take_out();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clm_state_decoder.md
CLM_STATE_DECODER -- requirements
Module: clm_state_decoder

Interface
REQ-001 The block SHALL have parameter d, default types::d, meaning the number of CLM redundancy bits per encoded byte.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_data, input, state_t (8+d bits): one CLM-encoded byte, with [0:7] the payload and [8:7+d] the refresh/redundancy part.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-007 The block SHALL have port dec_B, input, dec_matrix_t (d rows x 8 bits): the redundancy-to-payload decode matrix, i.e. the systematic part of B_ext_MC.
REQ-008 The block SHALL have port flush, input, 1 bit: abort the current block.
REQ-009 The block SHALL have port out_block, output, 16x8 bits: the decoded AES state, where byte k is the k-th accepted input.
REQ-010 The block SHALL have port out_valid, input/output direction output, 1 bit: out_block is complete.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes out_block.

Function
REQ-012 The block SHALL decode each byte as payload = in_data[0:7] XOR (XOR over j of (in_data[8+j] AND dec_B[j])), with bit index 0 as the MSB.
REQ-013 An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-014 The FSM SHALL have two states: COLLECT and DRAIN.
REQ-015 In COLLECT, in_ready SHALL be high while acc_cnt < 16; acc_cnt is a 5-bit count of accepted bytes.
REQ-016 The decoded byte SHALL be written to buffer slot acc_cnt (or slot acc_cnt-1 when the pipe stage is used, per REQ-024).
REQ-017 The block SHALL move COLLECT -> DRAIN in the cycle the 16th decoded byte is written, and out_valid SHALL rise in the next cycle.
REQ-018 In DRAIN, in_ready SHALL be 0, and out_valid and out_block SHALL hold stable until the output transfer.
REQ-019 An output transfer SHALL move the block DRAIN -> COLLECT and clear acc_cnt; no input SHALL be accepted in that same cycle.
REQ-020 flush SHALL clear acc_cnt, discard any pending pipe byte, force COLLECT and deassert out_valid the next cycle, and SHALL take priority over any simultaneous transfer.
REQ-021 dec_B SHALL be sampled combinationally at decode time; the user SHALL keep dec_B stable from the first acceptance until DRAIN.
REQ-022 out_block slots not yet written SHALL read as 0 after reset or flush.

Reset
REQ-023 When rst_n=0 at a clk edge, the block SHALL enter COLLECT with acc_cnt=0, buffer=0, out_valid=0, in_ready=1 (the next cycle), and the pipe stage empty.

Configuration
REQ-024 With CLM_DEC_PIPE_EN defined, each accepted byte SHALL be registered raw and decoded one cycle later, giving 16th-accept-to-out_valid latency = 2 cycles.
REQ-025 Without CLM_DEC_PIPE_EN, each accepted byte SHALL be decoded and written in its acceptance cycle, giving a latency of 1 cycle, and the pipe register SHALL be absent.

Structure
REQ-026 Package types (clm_typedefs.svh) SHALL hold dec_matrix_t and the block-size constant of 16.
REQ-027 Package types SHALL hold the FSM enum clm_dec_state_t.
REQ-028 A combinational sub-module clm_byte_decode (in_data, dec_B -> payload) SHALL implement REQ-012.

Verification
REQ-029 With d=2, dec_B={0x1B,0x80}, the bench SHALL send 16 bytes 0x53 with r=00; the block SHALL produce out_block all 0x53, with out_valid 1 cycle after the 16th accept (2 cycles with the pipe).
REQ-030 The bench SHALL send payload 0x53 with r=10, then r=11; the block SHALL decode these to 0x48 and 0xC8.
REQ-031 The bench SHALL hold out_ready=0 for 5 cycles in DRAIN; out_block SHALL stay stable, in_ready SHALL stay 0, and extra in_valid SHALL be ignored.
REQ-032 The bench SHALL flush after 7 accepts and then send 16 bytes 0x00..0x0F with r=00; the block SHALL produce out_block = 0x00..0x0F.
REQ-033 The bench SHALL assert rst_n=0 during DRAIN; out_valid SHALL be 0 the next cycle and the buffer SHALL read as all 0.
REQ-034 The bench SHALL assert flush and out_ready in the same cycle in DRAIN; the block SHALL go to COLLECT with acc_cnt=0 and out_valid=0.
